riscv_mc_controller: RTL and testbench
======================================

// Module: riscv_mc_controller
// PURPOSE
//  Multicycle RV32I control FSM that drives the datapath ALU: issues alu_control and mux selects, consumes the V/Z/N/Carry flags for branches.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction with a req/ready memory handshake.
//  Counts retired instructions.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter (wraps)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  op           in   7   instruction opcode (IR[6:0])
//  funct3       in   3   IR[14:12]
//  funct7b5     in   1   IR[30]
//  V,Z,N,Carry  in   1   ALU flags (Carry = NOT borrow on SUB)
//  mem_ready    in   1   memory completes current access this cycle
//  mem_req      out  1   memory access request
//  mem_write    out  1   store strobe (qualified by mem_req)
//  adr_src      out  1   0=PC, 1=ALUOut
//  ir_write     out  1   latch instruction
//  pc_write     out  1   update PC from result mux
//  reg_write    out  1   register-file write
//  alu_src_a    out  2   00=PC 01=oldPC 10=rs1 11=zero
//  alu_src_b    out  2   00=rs2 01=imm 10=const 4
//  result_src   out  2   00=ALUOut 01=mem data 10=ALU result
//  alu_control  out  4   0000 AND,0001 OR,0010 ADD,0110 SUB,0111 SLT,1100 SLTU,1000 XOR,1001 SLL,1010 SRL,1011 SRA
//  retired      out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Outputs are Moore decode of state (plus mem_ready/flags where noted). rst_n=0 at edge: state<=FETCH, retired<=0; all strobes forced 0 while rst_n=0.
//  Default each state: all strobes 0, selects 0, alu_control=ADD.
//  FETCH: mem_req, adr_src=0, a=00,b=10,ADD,result_src=10; ir_write=pc_write=mem_ready; stay until mem_ready -> DECODE.
//  DECODE: a=01,b=01,ADD (branch/jump target to ALUOut). Next: 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1101111->JAL, 1100011->BRANCH, 0110111->LUI, other->ILLEGAL handling (see CONFIGURATION).
//  MEMADR: a=10,b=01,ADD -> MEMREAD if op=0000011 else MEMWRITE.
//  MEMREAD: mem_req,adr_src=1; wait mem_ready -> MEMWB.  MEMWB: result_src=01,reg_write -> FETCH (retire).
//  MEMWRITE: mem_req,mem_write,adr_src=1; wait mem_ready -> FETCH (retire).
//  EXEC_R: a=10,b=00, ALU decode -> ALUWB.  EXEC_I: a=10,b=01, ALU decode -> ALUWB.
//  LUI: a=11,b=01,ADD -> ALUWB.  ALUWB: result_src=00,reg_write -> FETCH (retire).
//  JAL: a=01,b=10,ADD,result_src=00 (target),pc_write -> ALUWB.
//  BRANCH: a=10,b=00,SUB,result_src=00; pc_write=taken -> FETCH (retire). taken by funct3: 000 Z, 001 !Z, 100 N^V, 101 !(N^V), 110 !Carry, 111 Carry; 010/011 never.
//  ALU decode (funct3): 000 ADD (SUB if EXEC_R & funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7b5 (both R and I), 110 OR, 111 AND.
//  Retire: retired+1 on the edge leaving a terminal state; wraps 2^CNT_W-1 -> 0. Memory wait states hold outputs stable; mem_ready outside a mem_req state ignored.
//  Reset mid-wait (e.g. in MEMWRITE) abandons access: next cycle FETCH, no retire.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> ILLEGAL state, output illegal_o(1) high, all strobes 0, held until reset; no retire.
//  Not defined: unknown opcode -> FETCH as a no-op, retired increments; no illegal_o port.
// STRUCTURE
//  riscv_ctrl_pkg: state_t enum, alu_ctrl_e enum (codes above), opcode localparams, select encodings.
//  Sub-module riscv_alu_dec: combinational funct3/funct7b5/is_rtype -> alu_control.
// TESTING
//  Reset: rst_n=0 2 cycles, mem_ready=0 -> state FETCH, mem_req=1, pc_write=0, retired=0.
//  add R-type (op=0110011,f3=000,f7b5=0), mem_ready=1 in FETCH -> FETCH,DECODE,EXEC_R(alu 0010),ALUWB(reg_write) ; retired=1. f7b5=1 -> alu 0110.
//  lw with mem_ready low 3 cycles in MEMREAD -> outputs held, MEMWB after ready, reg_write one cycle, result_src=01.
//  beq Z=1 -> pc_write=1 in BRANCH; bltu Carry=1 -> pc_write=0; bge N=1,V=1 -> pc_write=1.
//  srai (op=0010011,f3=101,f7b5=1) -> alu 1011; sw -> mem_write only with mem_req, retire on ready.
//  op=1111111 -> with CTRL_ILLEGAL_TRAP_EN illegal_o=1 stuck, retired unchanged; without -> FETCH, retired+1. retired at all-ones + retire -> 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multicycle RV32I controller: FSM states, ALU control codes,
// opcodes and datapath mux-select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_JAL,
    S_BRANCH,
    S_LUI,
    S_ILLEGAL
  } state_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1100,
    ALU_XOR  = 4'b1000,
    ALU_SLL  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011
  } alu_ctrl_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/riscv_alu_dec.sv
// Combinational ALU operation decode from funct3/funct7b5; zero latency, no flow control.
module riscv_alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [3:0] alu_control
);

  alu_ctrl_e op_sel;

  // IR[30] selects SUB only for register ops (it is immediate data for ADDI),
  // but selects SRA for both register and immediate shifts.
  always_comb begin
    op_sel = ALU_ADD;
    case (funct3)
      3'b000:  op_sel = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op_sel = ALU_SLL;
      3'b010:  op_sel = ALU_SLT;
      3'b011:  op_sel = ALU_SLTU;
      3'b100:  op_sel = ALU_XOR;
      3'b101:  op_sel = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op_sel = ALU_OR;
      default: op_sel = ALU_AND;
    endcase
  end

  assign alu_control = op_sel;

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM (Moore outputs, mem waits held on mem_ready) with retire counter.
// CTRL_ILLEGAL_TRAP_EN: unknown opcodes lock into an ILLEGAL state flagged on illegal_o.
module riscv_mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             V,
  input  logic             Z,
  input  logic             N,
  input  logic             Carry,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [3:0]       alu_control,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic             illegal_o,
`endif
  output logic [CNT_W-1:0] retired
);

  state_t     state, state_nxt;
  logic       retire;
  logic       taken;
  logic [3:0] dec_alu;
  logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

  riscv_alu_dec u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (state == S_EXEC_R),
    .alu_control (dec_alu)
  );

  // Flags come from rs1 - rs2; Carry is NOT borrow, so !Carry means unsigned less-than.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Z;
      3'b001:  taken = ~Z;
      3'b100:  taken = N ^ V;
      3'b101:  taken = ~(N ^ V);
      3'b110:  taken = ~Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    adr_src     = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXEC_R;
          OP_ITYPE:          state_nxt = S_EXEC_I;
          OP_JAL:            state_nxt = S_JAL;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_LUI:            state_nxt = S_LUI;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_nxt = S_ILLEGAL;
`else
            state_nxt = S_FETCH;
            retire    = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_MEM;
        reg_write_c = 1'b1;
        state_nxt   = S_FETCH;
        retire      = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = dec_alu;
        state_nxt   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
        state_nxt   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_nxt   = S_FETCH;
        retire      = 1'b1;
      end
      // Jump target was parked in ALUOut by DECODE; the ALU meanwhile forms PC+4 for rd.
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_nxt  = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        pc_write_c  = taken;
        state_nxt   = S_FETCH;
        retire      = 1'b1;
      end
      default: state_nxt = state;
    endcase
  end

  assign mem_req   = rst_n & mem_req_c;
  assign mem_write = rst_n & mem_write_c;
  assign ir_write  = rst_n & ir_write_c;
  assign pc_write  = rst_n & pc_write_c;
  assign reg_write = rst_n & reg_write_c;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = rst_n & (state == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller: directed cases then random instruction mix
// against a per-instruction expected-cycle model.
module tb_riscv_mc_controller;

  localparam int CW = 4;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110,
                         A_SLT = 4'b0111, A_SLTU = 4'b1100, A_XOR = 4'b1000, A_SLL = 4'b1001,
                         A_SRL = 4'b1010, A_SRA = 4'b1011;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_JAL = 4, K_BR = 5, K_LUI = 6, K_BAD = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, funct7b5, V, Z, N, Carry, mem_ready;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, result_src;
  logic [3:0]    alu_control;
  logic [CW-1:0] retired;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic          illegal_o;
`endif

  riscv_mc_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .V(V), .Z(Z), .N(N), .Carry(Carry), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_control(alu_control),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_o(illegal_o),
`endif
    .retired(retired)
  );

  logic [15:0] outs;
  logic [4:0]  strb;
  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_control};
  assign strb = {mem_req, mem_write, ir_write, pc_write, reg_write};

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_ret;
  logic          exp_ill;

  function automatic logic [15:0] pk(input logic mr, mw, as, irw, pcw, rw,
                                     input logic [1:0] a, b, rs, input logic [3:0] alu);
    return {mr, mw, as, irw, pcw, rw, a, b, rs, alu};
  endfunction

  function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7, input logic isr);
    case (f3)
      3'd0:    return (isr && f7) ? A_SUB : A_ADD;
      3'd1:    return A_SLL;
      3'd2:    return A_SLT;
      3'd3:    return A_SLTU;
      3'd4:    return A_XOR;
      3'd5:    return f7 ? A_SRA : A_SRL;
      3'd6:    return A_OR;
      default: return A_AND;
    endcase
  endfunction

  // fl = {V,Z,N,Carry}
  function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
    logic lt_s, lt_u;
    lt_s = fl[1] != fl[3];
    lt_u = !fl[0];
    case (f3)
      3'd0:    return fl[2];
      3'd1:    return !fl[2];
      3'd4:    return lt_s;
      3'd5:    return !lt_s;
      3'd6:    return lt_u;
      3'd7:    return !lt_u;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int k);
    logic [6:0] bad [4];
    bad[0] = 7'b1111111; bad[1] = 7'b0010111; bad[2] = 7'b1100111; bad[3] = 7'b0000000;
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_JAL:   return 7'b1101111;
      K_BR:    return 7'b1100011;
      K_LUI:   return 7'b0110111;
      default: return bad[$urandom_range(0, 3)];
    endcase
  endfunction

  task automatic step(input logic [15:0] e, input string tag);
    #3;
    checks++;
    assert (outs === e) else begin
      errors++;
      $error("FAIL %s: outputs observed %h expected %h", tag, outs, e);
    end
    checks++;
    assert (retired === exp_ret) else begin
      errors++;
      $error("FAIL %s_retired: observed %0d expected %0d", tag, retired, exp_ret);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    assert (illegal_o === exp_ill) else begin
      errors++;
      $error("FAIL %s_illegal: observed %b expected %b", tag, illegal_o, exp_ill);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_strobes(input string tag);
    #3;
    checks++;
    assert (strb === 5'b0) else begin
      errors++;
      $error("FAIL %s: strobes observed %b expected 00000", tag, strb);
    end
  endtask

  task automatic mem_wait(input logic [15:0] e, input int wm, input string tag);
    for (int i = 0; i < wm; i++) begin
      mem_ready = 1'b0;
      step(e, tag);
    end
    mem_ready = 1'b1;
    step(e, tag);
  endtask

  task automatic aluwb();
    mem_ready = 1'($urandom);
    step(pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, A_ADD), "aluwb");
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic fetch_decode(input int wf);
    for (int i = 0; i < wf; i++) begin
      mem_ready = 1'b0;
      step(pk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, A_ADD), "fetch_wait");
    end
    mem_ready = 1'b1;
    step(pk(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, A_ADD), "fetch");
    mem_ready = 1'($urandom);
    step(pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, A_ADD), "decode");
  endtask

  task automatic run_instr(input int k, input logic [2:0] f3, input logic f7,
                           input logic [3:0] fl, input int wf, input int wm);
    op = op_of(k);
    funct3 = f3;
    funct7b5 = f7;
    {V, Z, N, Carry} = fl;
    fetch_decode(wf);
    case (k)
      K_R: begin
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, exp_alu(f3, f7, 1'b1)), "exec_r");
        aluwb();
      end
      K_I: begin
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, exp_alu(f3, f7, 1'b0)), "exec_i");
        aluwb();
      end
      K_LUI: begin
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, A_ADD), "lui");
        aluwb();
      end
      K_JAL: begin
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, A_ADD), "jal");
        aluwb();
      end
      K_LW: begin
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, A_ADD), "memadr");
        mem_wait(pk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD), wm, "memread");
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, A_ADD), "memwb");
        exp_ret = exp_ret + 1'b1;
      end
      K_SW: begin
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, A_ADD), "memadr");
        mem_wait(pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD), wm, "memwrite");
        exp_ret = exp_ret + 1'b1;
      end
      K_BR: begin
        mem_ready = 1'($urandom);
        step(pk(0, 0, 0, 0, br_taken(f3, fl), 0, 2'b10, 2'b00, 2'b00, A_SUB), "branch");
        exp_ret = exp_ret + 1'b1;
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        for (int i = 0; i < 4; i++) begin
          mem_ready = 1'($urandom);
          step(pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD), "illegal_hold");
        end
        rst_n = 1'b0;
        check_reset_strobes("illegal_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_ill = 1'b0;
        exp_ret = '0;
`else
        exp_ret = exp_ret + 1'b1;
`endif
      end
    endcase
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    {V, Z, N, Carry} = 4'b0;
    exp_ret = '0;
    exp_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_strobes("reset_strobes");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases
    run_instr(K_R,   3'b000, 1'b0, 4'b0000, 1, 0);  // add
    run_instr(K_R,   3'b000, 1'b1, 4'b0000, 0, 0);  // sub
    run_instr(K_LW,  3'b010, 1'b0, 4'b0000, 0, 3);  // lw with 3 wait cycles
    run_instr(K_BR,  3'b000, 1'b0, 4'b0100, 0, 0);  // beq Z=1 taken
    run_instr(K_BR,  3'b110, 1'b0, 4'b0001, 0, 0);  // bltu Carry=1 not taken
    run_instr(K_BR,  3'b101, 1'b0, 4'b1010, 0, 0);  // bge N=V=1 taken
    run_instr(K_I,   3'b101, 1'b1, 4'b0000, 0, 0);  // srai
    run_instr(K_SW,  3'b010, 1'b0, 4'b0000, 2, 2);  // sw
    run_instr(K_JAL, 3'b000, 1'b0, 4'b0000, 0, 0);
    run_instr(K_LUI, 3'b000, 1'b0, 4'b0000, 0, 0);
    run_instr(K_BR,  3'b010, 1'b0, 4'b1111, 0, 0);  // funct3 010 never taken
    run_instr(K_BAD, 3'b000, 1'b0, 4'b0000, 0, 0);

    // Random instruction mix
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 7), 3'($urandom), 1'($urandom), 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Counter wrap at all-ones
    while (exp_ret != {CW{1'b1}}) run_instr(K_R, 3'($urandom), 1'($urandom), 4'b0, 0, 0);
    run_instr(K_I, 3'b000, 1'b0, 4'b0, 0, 0);
    #3;
    checks++;
    assert (retired === {CW{1'b0}}) else begin
      errors++;
      $error("FAIL retired_wrap: observed %0d expected 0", retired);
    end
    @(posedge clk);
    #1;
    // That extra cycle sat in FETCH with mem_ready from the last step; realign by resetting.
    rst_n = 1'b0;
    check_reset_strobes("realign_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = '0;

    // Reset in the middle of a store wait abandons it without retiring
    run_instr(K_R, 3'b000, 1'b0, 4'b0, 0, 0);
    op = op_of(K_SW);
    fetch_decode(0);
    mem_ready = 1'b0;
    step(pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, A_ADD), "memadr");
    step(pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD), "memwrite_wait");
    rst_n = 1'b0;
    mem_ready = 1'b1;
    check_reset_strobes("midwait_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    exp_ret = '0;
    step(pk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, A_ADD), "fetch_after_abort");
    run_instr(K_LUI, 3'b000, 1'b0, 4'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
